// File: rtl/idwt_haar8_recon.sv
// Inverse 3-level integer Haar (S-transform) reconstruction for 8-sample frames.
// Loads A3,D3,D2[0..1],D1[0..3], runs one in-place lifting pair per cycle, then streams x[0..7].
module idwt_haar8_recon #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] coef_in,
  input  logic              coef_valid,
  output logic              coef_ready,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              level_done,
  output logic [1:0]        level_id,
  output logic              frame_done,
  output logic              busy
);

  localparam logic [2:0] ST_LOAD = 3'd0;
  localparam logic [2:0] ST_REC3 = 3'd1;
  localparam logic [2:0] ST_REC2 = 3'd2;
  localparam logic [2:0] ST_REC1 = 3'd3;
  localparam logic [2:0] ST_OUT  = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [2:0]               cnt_q, cnt_d;
  logic [1:0]               j_q, j_d;
  logic signed [DATA_W-1:0] c_q [8];
  logic signed [DATA_W-1:0] c_d [8];
  logic signed [DATA_W-1:0] a_q [8];
  logic signed [DATA_W-1:0] a_d [8];

  logic [2:0]               n_s;
  logic [2:0]               d_idx_s;
  logic signed [DATA_W-1:0] s_s, d_s, e_s, o_s;

  // Lifting datapath: detail for pair j of a level with N pairs sits at c[N+j].
  always_comb begin
    n_s      = 3'd0;
    level_id = 2'd0;
    case (state_q)
      ST_REC3: begin n_s = 3'd1; level_id = 2'd3; end
      ST_REC2: begin n_s = 3'd2; level_id = 2'd2; end
      ST_REC1: begin n_s = 3'd4; level_id = 2'd1; end
      default: begin n_s = 3'd0; level_id = 2'd0; end
    endcase
    d_idx_s = n_s + {1'b0, j_q};
    s_s     = a_q[{1'b0, j_q}];
    d_s     = c_q[d_idx_s];
    e_s     = s_s - (d_s >>> 1);
    o_s     = d_s + e_s;
  end

  // Next-state logic; j descends so in-place writes at 2j,2j+1 never clobber a pending read.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    c_d     = c_q;
    a_d     = a_q;
    case (state_q)
      ST_LOAD: begin
        if (coef_valid) begin
          c_d[cnt_q] = $signed(coef_in);
          if (cnt_q == 3'd7) begin
            a_d[0]  = c_q[0];
            cnt_d   = 3'd0;
            j_d     = 2'd0;
            state_d = ST_REC3;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_REC3, ST_REC2, ST_REC1: begin
        a_d[{j_q, 1'b0}] = e_s;
        a_d[{j_q, 1'b1}] = o_s;
        if (j_q == 2'd0) begin
          case (state_q)
            ST_REC3: begin state_d = ST_REC2; j_d = 2'd1; end
            ST_REC2: begin state_d = ST_REC1; j_d = 2'd3; end
            default: begin state_d = ST_OUT;  j_d = 2'd0; end
          endcase
        end else begin
          j_d = j_q - 2'd1;
        end
      end
      ST_OUT: begin
        if (sample_ready) begin
          if (cnt_q == 3'd7) begin
            cnt_d   = 3'd0;
            state_d = ST_LOAD;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_LOAD;
        cnt_d   = 3'd0;
        j_d     = 2'd0;
      end
    endcase
  end

  // State and storage registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_LOAD;
      cnt_q   <= 3'd0;
      j_q     <= 2'd0;
      for (int i = 0; i < 8; i++) begin
        c_q[i] <= {DATA_W{1'b0}};
        a_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      c_q     <= c_d;
      a_q     <= a_d;
    end
  end

  assign coef_ready   = (state_q == ST_LOAD);
  assign busy         = (state_q != ST_LOAD);
  assign sample_valid = (state_q == ST_OUT);
  assign sample_out   = a_q[cnt_q];
  assign frame_done   = sample_valid & sample_ready & (cnt_q == 3'd7);
  assign level_done   = (level_id != 2'd0) & (j_q == 2'd0);

endmodule

// File: tb/tb_idwt_haar8_recon.sv
// Directed + randomized bench for idwt_haar8_recon; random frames are checked against a
// level-by-level inverse Haar model built from plain integer arithmetic.
module tb_idwt_haar8_recon;

  typedef logic [15:0] frame_t [8];

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] coef_in;
  logic        coef_valid;
  logic        coef_ready;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        sample_ready;
  logic        level_done;
  logic [1:0]  level_id;
  logic        frame_done;
  logic        busy;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int t_last = 0;

  idwt_haar8_recon #(.DATA_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .coef_in(coef_in), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .level_done(level_done), .level_id(level_id), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic int floor_half(input int v);
    if (v >= 0) return v / 2;
    else return -((1 - v) / 2);
  endfunction

  // Reference: start from A3, each level expands N approximations into 2N using N details.
  task automatic model(input frame_t cf, output frame_t xs);
    int ap[$];
    int nx[$];
    int n, d, e, o, t;
    ap = {};
    ap.push_back(int'($signed(cf[0])));
    n = 1;
    while (n < 8) begin
      nx = {};
      for (int k = 0; k < n; k++) begin
        d = int'($signed(cf[n + k]));
        e = wrap16(ap[k] - floor_half(d));
        o = wrap16(d + e);
        nx.push_back(e);
        nx.push_back(o);
      end
      ap = nx;
      n = n * 2;
    end
    for (int k = 0; k < 8; k++) begin
      t = ap[k];
      xs[k] = t[15:0];
    end
  endtask

  task automatic send_frame(input frame_t cf, input bit gapped);
    int  waited;
    bit  done;
    for (int i = 0; i < 8; i++) begin
      waited = 0;
      done   = 1'b0;
      while (!done) begin
        @(negedge clk);
        coef_in    = cf[i];
        coef_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (coef_valid && coef_ready) begin
          done   = 1'b1;
          t_last = cyc;
        end else begin
          waited++;
          if (waited > 40) begin
            check("coef_accept_timeout", 32'd0, 32'd1);
            return;
          end
        end
      end
    end
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1,..., 2: random ready.
  task automatic receive_frame(input frame_t exp, input int mode);
    int          k, off, budget, p;
    logic [15:0] held;
    bit          stalled, first;
    k = 0; budget = 0; p = 0; held = 16'd0; stalled = 1'b0; first = 1'b1;
    while (k < 8) begin
      @(negedge clk);
      if (mode == 0)      sample_ready = 1'b1;
      else if (mode == 1) sample_ready = ((p % 4) == 0) || ((p % 4) == 3);
      else                sample_ready = 1'($urandom_range(0, 1));
      p++;
      coef_valid = 1'($urandom_range(0, 1));
      coef_in    = 16'($urandom);
      #1;
      off = cyc - t_last;
      if (off >= 1 && off <= 7) begin
        check("level_done", 32'(level_done), 32'((off == 1) || (off == 3) || (off == 7)));
        check("level_id", 32'(level_id), (off == 1) ? 32'd3 : (off <= 3) ? 32'd2 : 32'd1);
        check("rec_flags", 32'({busy, coef_ready, sample_valid}), 32'b100);
      end
      if (sample_valid) begin
        if (first) begin
          check("first_valid_latency", 32'(off), 32'd8);
          first = 1'b0;
        end
        if (stalled) check("stall_hold", 32'(sample_out), 32'(held));
        check("sample", 32'(sample_out), 32'(exp[k]));
        check("frame_done", 32'(frame_done), 32'(sample_ready && (k == 7)));
        if (sample_ready) begin
          k++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = sample_out;
        end
      end
      budget++;
      if (budget > 200) begin
        check("sample_timeout", 32'd0, 32'd1);
        return;
      end
    end
    @(negedge clk);
    sample_ready = 1'b0;
    coef_valid   = 1'b0;
    #1;
    check("coef_ready_after_frame", 32'(coef_ready), 32'd1);
    check("busy_after_frame", 32'(busy), 32'd0);
    check("level_id_idle", 32'(level_id), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_coef_ready"}, 32'(coef_ready), 32'd1);
    check({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
    check({tag, "_sample_out"}, 32'(sample_out), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_level"}, 32'({level_done, level_id, frame_done}), 32'd0);
  endtask

  initial begin
    frame_t known, known_exp, floor_in, floor_exp, const_in, const_exp, wrap_in, xs, rnd;
    int waited;
    known     = '{16'd8, 16'hFFF4, 16'd6, 16'd9, 16'd2, 16'd6, 16'hFFFC, 16'd0};
    known_exp = '{16'd10, 16'd12, 16'd14, 16'd20, 16'd0, 16'hFFFC, 16'd7, 16'd7};
    floor_in  = '{16'd0, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    floor_exp = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
    const_in  = '{16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    const_exp = '{16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5};
    wrap_in   = '{16'h7FFF, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};

    reset_n = 1'b0; coef_in = 16'd0; coef_valid = 1'b0; sample_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    send_frame(known, 1'b0);
    receive_frame(known_exp, 0);

    send_frame(floor_in, 1'b0);
    receive_frame(floor_exp, 0);

    send_frame(const_in, 1'b0);
    receive_frame(const_exp, 0);
    send_frame(known, 1'b0);
    receive_frame(known_exp, 0);

    send_frame(known, 1'b1);
    receive_frame(known_exp, 1);

    // Reset in the middle of REC2, then a clean frame.
    send_frame(known, 1'b0);
    waited = 0;
    do begin
      @(negedge clk);
      #1;
      waited++;
    end while (level_id != 2'd2 && waited < 20);
    check("reach_rec2", 32'(level_id), 32'd2);
    reset_n = 1'b0;
    coef_valid = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    send_frame(known, 1'b0);
    receive_frame(known_exp, 0);

    model(wrap_in, xs);
    send_frame(wrap_in, 1'b0);
    receive_frame(xs, 0);

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 8; i++) rnd[i] = 16'($urandom);
      model(rnd, xs);
      send_frame(rnd, 1'b1);
      receive_frame(xs, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
